// File: rtl/seg_scan_mux_if.sv
// Bus bundle for seg_scan_mux: value/load toward the scanner and the
// display drive and status signals coming back from it.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic [3:0]              digit_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output value_in, load,
        input  digit_out, anode_n, pending, frame_tick
    );

    modport slave (
        input  value_in, load,
        output digit_out, anode_n, pending, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Double-buffered multi-digit 7-segment scanner with per-slot dead time.
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_mux_if.slave    bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [CW-1:0]         slot_cnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [VW-1:0]         shadow_reg;
    logic [VW-1:0]         display_reg;
    logic                  pending_reg;
    logic [NUM_DIGITS-1:0] anode_reg;
    logic [3:0]            digit_reg;
    logic                  frame_tick_reg;

    logic                  slot_last;
    logic                  idx_last;
    logic                  wrap;
    logic                  dead;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [3:0]            digit_sel;
    logic [3:0]            nib [NUM_DIGITS];

    assign slot_last = (slot_cnt_reg == CW'(SCAN_DIV - 1));
    assign idx_last  = (idx_reg == IW'(NUM_DIGITS - 1));
    assign wrap      = slot_last && idx_last;
    assign dead      = (slot_cnt_reg < CW'(DEAD_CYCLES));
    assign anode_sel = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_reg);
    assign digit_sel = nib[idx_reg];

    // Per-digit code presented to the decoder, after optional blanking.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_units
                assign nib[gi] = display_reg[3:0];
            end else begin : g_upper
                logic upper_zero;
                assign upper_zero = (display_reg[VW-1:4*gi] == '0);
                assign nib[gi]    = upper_zero ? 4'hF : display_reg[4*gi +: 4];
            end
`else
            assign nib[gi] = display_reg[4*gi +: 4];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_reg   <= '0;
            idx_reg        <= '0;
            shadow_reg     <= '0;
            display_reg    <= '0;
            pending_reg    <= 1'b0;
            anode_reg      <= '1;
            digit_reg      <= 4'hF;
            frame_tick_reg <= 1'b0;
        end else begin
            slot_cnt_reg <= slot_last ? '0 : slot_cnt_reg + CW'(1);
            if (slot_last) begin
                idx_reg <= idx_last ? '0 : idx_reg + IW'(1);
            end
            // A load on the wrap edge wins and defers the swap by one frame.
            if (bus.load) begin
                shadow_reg  <= bus.value_in;
                pending_reg <= 1'b1;
            end else if (wrap && pending_reg) begin
                display_reg <= shadow_reg;
                pending_reg <= 1'b0;
            end
            frame_tick_reg <= wrap;
            anode_reg      <= dead ? '1 : anode_sel;
            digit_reg      <= dead ? 4'hF : digit_sel;
        end
    end

    assign bus.anode_n    = anode_reg;
    assign bus.digit_out  = digit_reg;
    assign bus.pending    = pending_reg;
    assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1.
// Output position p counts edges after reset release; frame m spans p = 16m..16m+15.
module tb_seg_scan_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [15:0] val;
        logic [15:0] shown_plain;
        logic [15:0] shown_lz;
    } vec_t;

    vec_t        vecs [6];
    int          p;
    logic [15:0] disp_m;
    logic [15:0] shadow_m;
    logic        pend_m;
    logic [15:0] ld_show;
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [15:0] pick(input logic [15:0] plain, input logic [15:0] lz);
`ifdef LEADING_ZERO_BLANK_EN
        return lz;
`else
        return plain;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s p=%0d actual=%h required=%h", name, p, act, req);
    endtask

    // One clock: predict outputs from the pre-edge display, update the model, compare.
    task automatic tick();
        logic [3:0] e_an;
        logic [3:0] e_dg;
        int slot;
        int idx;
        @(posedge clk);
        p++;
        slot = p % 4;
        idx  = (p / 4) % 4;
        e_an = (slot < 1) ? 4'hF : (4'hF ^ (4'b0001 << idx));
        e_dg = (slot < 1) ? 4'hF : disp_m[4*idx +: 4];
        if (bus.load) begin
            shadow_m = ld_show;
            pend_m   = 1'b1;
        end else if ((p % 16 == 15) && pend_m) begin
            disp_m = shadow_m;
            pend_m = 1'b0;
        end
        @(negedge clk);
        check("anode_n",    {12'h0, bus.anode_n},   {12'h0, e_an});
        check("digit_out",  {12'h0, bus.digit_out}, {12'h0, e_dg});
        check("frame_tick", {15'h0, bus.frame_tick}, {15'h0, (p % 16 == 15)});
        check("pending",    {15'h0, bus.pending},   {15'h0, pend_m});
        check("one_anode",  {15'h0, ($countones(~bus.anode_n) <= 1)}, 16'h1);
    endtask

    task automatic run_to(input int phase);
        while (p % 16 != phase) tick();
    endtask

    task automatic load_at(input int phase, input logic [15:0] val, input logic [15:0] shown);
        run_to(phase);
        bus.value_in = val;
        bus.load     = 1'b1;
        ld_show      = shown;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic model_reset();
        p        = -1;
        disp_m   = pick(16'h0000, 16'hFFF0);
        shadow_m = disp_m;
        pend_m   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 16'h1234};
        vecs[1] = '{16'h0050, 16'h0050, 16'hFF50};
        vecs[2] = '{16'h0000, 16'h0000, 16'hFFF0};
        vecs[3] = '{16'h0102, 16'h0102, 16'hF102};
        vecs[4] = '{16'hA0F0, 16'hA0F0, 16'hA0F0};
        vecs[5] = '{16'h0800, 16'h0800, 16'hF800};

        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = 16'h0;
        ld_show      = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Scan a little, capture a value, then reset mid-frame.
        repeat (6) tick();
        bus.value_in = 16'h1234;
        bus.load     = 1'b1;
        ld_show      = 16'h1234;
        tick();
        bus.load     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_anode_n",    {12'h0, bus.anode_n},    16'h000F);
            check("rst_digit_out",  {12'h0, bus.digit_out},  16'h000F);
            check("rst_pending",    {15'h0, bus.pending},    16'h0000);
            check("rst_frame_tick", {15'h0, bus.frame_tick}, 16'h0000);
        end
        model_reset();
        rst_n = 1'b1;
        run_to(15);

        // Mid-frame load: old value for the rest of the frame, new value after the wrap.
        for (int v = 0; v < 6; v++) begin
            load_at(5, vecs[v].val, pick(vecs[v].shown_plain, vecs[v].shown_lz));
            run_to(15);
            tick();
            run_to(15);
            $display("vec %0d value=%h shown=%h p=%0d", v, vecs[v].val, disp_m, p);
        end

        // Load exactly on the wrap edge: swap deferred by a whole frame.
        load_at(14, 16'hBEEF, 16'hBEEF);
        check("wrap_load_pending", {15'h0, bus.pending}, 16'h0001);
        tick();
        run_to(15);
        tick();
        run_to(15);
        $display("wrap-edge load value=BEEF shown=%h p=%0d", disp_m, p);

        // Two loads in one frame: the last one is displayed.
        load_at(3, 16'h1111, 16'h1111);
        load_at(8, 16'h2222, 16'h2222);
        run_to(15);
        tick();
        run_to(15);
        check("last_load_wins", disp_m, 16'h2222);
        $display("double load value=2222 shown=%h p=%0d", disp_m, p);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
